// File: rtl/dist_pkt_pkg.sv
// Shared constants, state/phase encodings and the sample range-check helper
// for the distance packetizer.
package dist_pkt_pkg;

    localparam logic [7:0] PKT_HDR0 = 8'hA5;
    localparam logic [7:0] PKT_HDR1 = 8'h5A;

    typedef enum logic {
        S_FILL = 1'b0,
        S_SEND = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        PH_HDR0 = 3'd0,
        PH_HDR1 = 3'd1,
        PH_SEQ  = 3'd2,
        PH_CNT  = 3'd3,
        PH_HI   = 3'd4,
        PH_LO   = 3'd5,
        PH_CHK  = 3'd6
    } phase_t;

    // Full 32-bit range compare; anything outside [lo, hi] becomes the 0xFFFF marker.
    function automatic logic [15:0] dist_code(input logic [31:0] d,
                                              input logic [31:0] lo,
                                              input logic [31:0] hi);
        logic [15:0] code;
        if ((d >= lo) && (d <= hi)) begin
            code = d[15:0];
        end else begin
            code = 16'hFFFF;
        end
        return code;
    endfunction

endpackage

// File: rtl/dist_pkt_buf.sv
// Simple dual-port sample RAM with a registered read port (one cycle latency),
// left without reset so it maps onto distributed or block RAM.
module dist_pkt_buf
    import dist_pkt_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          i_clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [15:0]   i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [15:0]   o_rd_data
);

    logic [15:0] r_mem [DEPTH];
    logic [15:0] r_rd_data;

    // Write port and registered read port.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dist_packetizer.sv
// Range-checks 32-bit distance samples, buffers N_POINTS 16-bit codes and sends
// them as one framed, XOR-checksummed byte packet on a valid/ready stream.
module dist_packetizer
    import dist_pkt_pkg::*;
#(
    parameter int N_POINTS = 8,
    parameter int MIN_DIST = 10000,
    parameter int MAX_DIST = 15000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dist_valid,
    input  logic [31:0] dist_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_sop,
    output logic        tx_eop,
    output logic        busy,
    output logic [15:0] drop_cnt
);

    localparam int         AW       = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
    localparam logic [7:0] CNT_BYTE = 8'(N_POINTS);
    localparam logic [7:0] LAST_IDX = 8'(N_POINTS - 1);

    state_t      r_state, w_state;
    phase_t      r_phase, w_phase;
    logic [7:0]  r_idx, w_idx;
    logic [7:0]  r_pt, w_pt;
    logic [7:0]  r_seq, w_seq;
    logic [7:0]  r_chk, w_chk;
    logic [7:0]  r_lo, w_lo;
    logic [15:0] r_drop_cnt, w_drop_cnt;
    logic [7:0]  r_tx_data, w_tx_data;
    logic        r_tx_valid, w_tx_valid;
    logic        r_tx_sop, w_tx_sop;
    logic        r_tx_eop, w_tx_eop;

    logic [15:0]   w_code;
    logic          w_wr_en;
    logic          w_hs;
    logic [AW-1:0] w_rd_addr;
    logic [15:0]   w_rd_data;

    assign w_code    = dist_code(dist_data, 32'(MIN_DIST), 32'(MAX_DIST));
    assign w_wr_en   = (r_state == S_FILL) && dist_valid;
    assign w_hs      = r_tx_valid && tx_ready;
    // r_pt always names the next point to emit, so the RAM output is ready before it is needed.
    assign w_rd_addr = (r_pt < CNT_BYTE) ? r_pt[AW-1:0] : {AW{1'b0}};

    dist_pkt_buf #(
        .DEPTH(N_POINTS),
        .AW   (AW)
    ) u_buf (
        .i_clk    (clk),
        .i_wr_en  (w_wr_en),
        .i_wr_addr(r_idx[AW-1:0]),
        .i_wr_data(w_code),
        .i_rd_addr(w_rd_addr),
        .o_rd_data(w_rd_data)
    );

    // Next-state, byte sequencing, checksum and drop counting.
    always_comb begin
        w_state    = r_state;
        w_phase    = r_phase;
        w_idx      = r_idx;
        w_pt       = r_pt;
        w_seq      = r_seq;
        w_chk      = r_chk;
        w_lo       = r_lo;
        w_drop_cnt = r_drop_cnt;
        w_tx_data  = r_tx_data;
        w_tx_valid = r_tx_valid;
        w_tx_sop   = r_tx_sop;
        w_tx_eop   = r_tx_eop;
        case (r_state)
            S_FILL: begin
                if (dist_valid && (r_idx == LAST_IDX)) begin
                    w_idx      = 8'd0;
                    w_pt       = 8'd0;
                    w_chk      = 8'h00;
                    w_state    = S_SEND;
                    w_phase    = PH_HDR0;
                    w_tx_data  = PKT_HDR0;
                    w_tx_valid = 1'b1;
                    w_tx_sop   = 1'b1;
                    w_tx_eop   = 1'b0;
                end else if (dist_valid) begin
                    w_idx = r_idx + 8'd1;
                end else begin
                    w_idx = r_idx;
                end
            end
            S_SEND: begin
                if (dist_valid && (r_drop_cnt != 16'hFFFF)) begin
                    w_drop_cnt = r_drop_cnt + 16'd1;
                end else begin
                    w_drop_cnt = r_drop_cnt;
                end
                if (w_hs) begin
                    w_chk    = r_chk ^ r_tx_data;
                    w_tx_sop = 1'b0;
                    case (r_phase)
                        PH_HDR0: begin
                            w_phase   = PH_HDR1;
                            w_tx_data = PKT_HDR1;
                        end
                        PH_HDR1: begin
                            w_phase   = PH_SEQ;
                            w_tx_data = r_seq;
                        end
                        PH_SEQ: begin
                            w_phase   = PH_CNT;
                            w_tx_data = CNT_BYTE;
                        end
                        PH_CNT, PH_LO: begin
                            if (r_pt == CNT_BYTE) begin
                                w_phase   = PH_CHK;
                                w_tx_data = r_chk ^ r_tx_data;
                                w_tx_eop  = 1'b1;
                            end else begin
                                w_phase   = PH_HI;
                                w_tx_data = w_rd_data[15:8];
                                w_lo      = w_rd_data[7:0];
                                w_pt      = r_pt + 8'd1;
                            end
                        end
                        PH_HI: begin
                            w_phase   = PH_LO;
                            w_tx_data = r_lo;
                        end
                        PH_CHK: begin
                            w_state    = S_FILL;
                            w_phase    = PH_HDR0;
                            w_seq      = r_seq + 8'd1;
                            w_tx_data  = 8'h00;
                            w_tx_valid = 1'b0;
                            w_tx_eop   = 1'b0;
                        end
                        default: begin
                            w_state    = S_FILL;
                            w_phase    = PH_HDR0;
                            w_tx_data  = 8'h00;
                            w_tx_valid = 1'b0;
                            w_tx_eop   = 1'b0;
                        end
                    endcase
                end else begin
                    w_chk = r_chk;
                end
            end
            default: begin
                w_state    = S_FILL;
                w_tx_valid = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FILL;
            r_phase    <= PH_HDR0;
            r_idx      <= 8'd0;
            r_pt       <= 8'd0;
            r_seq      <= 8'd0;
            r_chk      <= 8'h00;
            r_lo       <= 8'h00;
            r_drop_cnt <= 16'd0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_tx_sop   <= 1'b0;
            r_tx_eop   <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_phase    <= w_phase;
            r_idx      <= w_idx;
            r_pt       <= w_pt;
            r_seq      <= w_seq;
            r_chk      <= w_chk;
            r_lo       <= w_lo;
            r_drop_cnt <= w_drop_cnt;
            r_tx_data  <= w_tx_data;
            r_tx_valid <= w_tx_valid;
            r_tx_sop   <= w_tx_sop;
            r_tx_eop   <= w_tx_eop;
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign tx_sop   = r_tx_sop;
    assign tx_eop   = r_tx_eop;
    assign busy     = (r_state == S_SEND);
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_dist_packetizer.sv
// Self-checking bench: a packet-level reference model predicts every output byte,
// flag and counter each cycle; literal checks pin a few hand-computed packets.
module tb_dist_packetizer;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dist_valid;
    logic [31:0] dist_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_sop;
    logic        tx_eop;
    logic        busy;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    dist_packetizer #(
        .N_POINTS(N),
        .MIN_DIST(10000),
        .MAX_DIST(15000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dist_valid(dist_valid),
        .dist_data (dist_data),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_sop    (tx_sop),
        .tx_eop    (tx_eop),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } pb_t;

    pb_t         exp_q[$];
    logic [15:0] m_fill[$];
    bit          m_sending;
    logic [7:0]  m_seq;
    logic [15:0] m_drop;
    logic [7:0]  pkt_log[$];
    int          n_checks;
    int          n_fail;
    int          cyc;
    int          eop_count;
    int          first_cyc;
    int          last_cyc;

    function automatic logic [15:0] to_code(input logic [31:0] v);
        if (v >= 32'd10000 && v <= 32'd15000) return v[15:0];
        else return 16'hFFFF;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic build_pkt();
        logic [7:0] b[$];
        logic [7:0] x;
        b = {8'hA5, 8'h5A, m_seq, 8'(N)};
        foreach (m_fill[i]) begin
            b.push_back(m_fill[i][15:8]);
            b.push_back(m_fill[i][7:0]);
        end
        x = 8'h00;
        foreach (b[i]) x = x ^ b[i];
        foreach (b[i]) exp_q.push_back('{d: b[i], sop: (i == 0), eop: 1'b0});
        exp_q.push_back('{d: x, sop: 1'b0, eop: 1'b1});
    endtask

    // One clock: check outputs at the falling edge, then drive inputs and advance the model.
    task automatic step(input logic dv, input logic [31:0] dd, input logic rdy, input logic rstv);
        bit  hs;
        pb_t b;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            check("rst_tx_valid", 32'(tx_valid), 32'd0);
            check("rst_tx_sop", 32'(tx_sop), 32'd0);
            check("rst_tx_eop", 32'(tx_eop), 32'd0);
            check("rst_tx_data", 32'(tx_data), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
            exp_q.delete();
            m_fill.delete();
            m_sending = 1'b0;
            m_seq = 8'd0;
            m_drop = 16'd0;
        end else begin
            check("busy", 32'(busy), 32'(m_sending));
            check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            check("tx_valid", 32'(tx_valid), 32'(m_sending));
            if (m_sending) begin
                if (exp_q.size() > 0) begin
                    check("tx_data", 32'(tx_data), 32'(exp_q[0].d));
                    check("tx_sop", 32'(tx_sop), 32'(exp_q[0].sop));
                    check("tx_eop", 32'(tx_eop), 32'(exp_q[0].eop));
                end else begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL model_queue at cycle %0d: got empty, want a byte", cyc);
                end
            end
        end
        dist_valid = dv;
        dist_data  = dd;
        tx_ready   = rdy;
        rst_n      = rstv;
        if (rstv) begin
            hs = m_sending && rdy;
            if (hs && tx_valid) begin
                if (tx_sop) begin
                    pkt_log.delete();
                    first_cyc = cyc;
                end
                pkt_log.push_back(tx_data);
                if (tx_eop) last_cyc = cyc;
            end
            if (dv) begin
                if (m_sending) begin
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                end else begin
                    m_fill.push_back(to_code(dd));
                end
            end
            if (hs && exp_q.size() > 0) begin
                b = exp_q.pop_front();
                if (b.eop) begin
                    m_sending = 1'b0;
                    m_seq = m_seq + 8'd1;
                    eop_count++;
                end
            end
            if (!m_sending && m_fill.size() == N) begin
                build_pkt();
                m_fill.delete();
                m_sending = 1'b1;
            end
        end
    endtask

    task automatic drain(input int rdy_pct, input int limit);
        int i;
        i = 0;
        while (m_sending && i < limit) begin
            step(1'b0, 32'd0, ($urandom_range(0, 99) < rdy_pct), 1'b1);
            i++;
        end
        check("drain_done", 32'(m_sending), 32'd0);
    endtask

    initial begin
        logic [31:0] t2[8];
        int          target;
        int          lim;
        logic [31:0] dd;
        n_checks = 0;
        n_fail = 0;
        cyc = 0;
        eop_count = 0;
        first_cyc = 0;
        last_cyc = 0;
        m_sending = 1'b0;
        m_seq = 8'd0;
        m_drop = 16'd0;
        rst_n = 1'b1;
        dist_valid = 1'b0;
        dist_data = 32'd0;
        tx_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) step(1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b1);

        // Back-to-back ramp 10000..10007 with the sink always ready.
        for (int k = 0; k < N; k++) step(1'b1, 32'(10000 + k), 1'b1, 1'b1);
        drain(100, 100);
        check("t1_len", 32'(pkt_log.size()), 32'd21);
        check("t1_contig", 32'(last_cyc - first_cyc), 32'd20);
        if (pkt_log.size() == 21) begin
            check("t1_b0", 32'(pkt_log[0]), 32'hA5);
            check("t1_b1", 32'(pkt_log[1]), 32'h5A);
            check("t1_seq", 32'(pkt_log[2]), 32'h00);
            check("t1_cnt", 32'(pkt_log[3]), 32'h08);
            check("t1_p0hi", 32'(pkt_log[4]), 32'h27);
            check("t1_p0lo", 32'(pkt_log[5]), 32'h10);
            check("t1_p7lo", 32'(pkt_log[19]), 32'h17);
            check("t1_chk", 32'(pkt_log[20]), 32'hF7);
        end

        // Range boundaries, including a value above 16 bits whose low half is in range.
        t2 = '{32'd9999, 32'd15001, 32'h0001_2710, 32'd15000,
               32'd10000, 32'hFFFF_FFFF, 32'd12345, 32'd0};
        for (int k = 0; k < N; k++) step(1'b1, t2[k], 1'b1, 1'b1);
        drain(100, 100);
        check("t2_len", 32'(pkt_log.size()), 32'd21);
        if (pkt_log.size() == 21) begin
            check("t2_seq", 32'(pkt_log[2]), 32'h01);
            check("t2_p0hi", 32'(pkt_log[4]), 32'hFF);
            check("t2_p2lo", 32'(pkt_log[9]), 32'hFF);
            check("t2_p3hi", 32'(pkt_log[10]), 32'h3A);
            check("t2_p3lo", 32'(pkt_log[11]), 32'h98);
            check("t2_p4hi", 32'(pkt_log[12]), 32'h27);
            check("t2_chk", 32'(pkt_log[20]), 32'h6A);
        end

        // Random samples, random gaps, random back-pressure and drops for three packets.
        target = eop_count + 3;
        lim = 0;
        while (eop_count < target && lim < 3000) begin
            if ($urandom_range(0, 9) == 0) dd = $urandom;
            else dd = 32'($urandom_range(9990, 15010));
            step(($urandom_range(0, 99) < 60), dd, ($urandom_range(0, 99) < 50), 1'b1);
            lim++;
        end
        check("t3_pkts", 32'(eop_count), 32'(target));
        if (pkt_log.size() > 2) check("t3_seq", 32'(pkt_log[2]), 32'h04);

        // Reset mid-packet after seven bytes have gone out.
        for (int k = 0; k < N; k++) step(1'b1, 32'(14000 + k), 1'b0, 1'b1);
        for (int k = 0; k < N; k++) step(1'b1, 32'(11000 + k), 1'b0, 1'b1);
        lim = 0;
        while (!(m_sending && pkt_log.size() == 7 && tx_sop == 1'b0) && lim < 200) begin
            step(1'b0, 32'd0, 1'b1, 1'b1);
            lim++;
        end
        check("t5_reach", 32'(pkt_log.size()), 32'd7);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_valid_async", 32'(tx_valid), 32'd0);
        check("t5_busy_async", 32'(busy), 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        for (int k = 0; k < N; k++) step(1'b1, 32'(13000 + k), 1'b1, 1'b1);
        drain(100, 100);
        check("t5_len", 32'(pkt_log.size()), 32'd21);
        if (pkt_log.size() == 21) begin
            check("t5_b0", 32'(pkt_log[0]), 32'hA5);
            check("t5_b1", 32'(pkt_log[1]), 32'h5A);
            check("t5_seq", 32'(pkt_log[2]), 32'h00);
            check("t5_p0hi", 32'(pkt_log[4]), 32'h32);
            check("t5_p0lo", 32'(pkt_log[5]), 32'hC8);
        end

        // dist_valid held high: only samples taken while filling reach the packet.
        dd = 32'd12000;
        for (int p = 0; p < 2; p++) begin
            target = eop_count + 1;
            lim = 0;
            while (eop_count < target && lim < 200) begin
                step(1'b1, dd, 1'b1, 1'b1);
                dd = dd + 32'd1;
                lim++;
            end
            check("t4_pkt", 32'(eop_count), 32'(target));
            @(posedge clk);
            #1;
            check("t4_drop", 32'(drop_cnt), 32'(21 * (p + 1)));
        end

        // Stalled sink with continuous samples drives drop_cnt into saturation.
        for (int k = 0; k < 70000; k++) step(1'b1, 32'(10500 + (k % 64)), 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("t6_drop_sat", 32'(drop_cnt), 32'h0000_FFFF);
        check("t6_stall_valid", 32'(tx_valid), 32'd1);
        check("t6_stall_data", 32'(tx_data), 32'hA5);
        repeat (5) step(1'b1, 32'd10001, 1'b0, 1'b1);
        drain(100, 100);
        step(1'b0, 32'd0, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
